fir_avg_stream: RTL

Parametrised, streaming N-tap unsigned moving-average FIR filter. It is the successor to the fixed 4-tap averaging filter and generalises it in three ways: configurable data width and tap count, a valid/ready handshake on input and output, and an O(1) running-sum datapath in place of an adder tree. It sits in the sample pipeline between the sample source and downstream consumers, and delivers both the full-precision window sum and the averaged sample.

---
 rtl/fir_avg_stream.sv | 82 ++++++++
 1 files changed

// File: rtl/fir_avg_stream.sv
// fir_avg_stream: streaming TAPS-tap unsigned moving-average filter with valid/ready handshake.
//   Running-sum datapath: each accepted sample adds itself and subtracts the sample it evicts.
//   Optional build macro FIR_AVG_ROUND_EN: round-half-up average instead of truncation.
//   Ports:
//     clk, reset      rising-edge clock, asynchronous active-high reset
//     flush           synchronous clear of window history and pending output
//     in_valid/ready  input handshake, in_data W-bit unsigned sample
//     out_valid/ready output handshake (single registered stage)
//     out_sum         W+LG-bit sum of the last TAPS accepted samples
//     out_avg         W-bit average (out_sum >> LG, rounded or truncated)
//     out_warm        window held TAPS real samples for this result
module fir_avg_stream #(
    parameter int W = 16,
    parameter int TAPS = 8,
    localparam int LG = $clog2(TAPS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W+LG-1:0] out_sum,
    output logic [W-1:0]    out_avg,
    output logic            out_warm
);
    if (W < 2 || W > 32 || TAPS < 2 || TAPS > 256 || (TAPS & (TAPS - 1)) != 0) begin : g_bad_cfg
        $fatal(1, "fir_avg_stream: W must be 2..32 and TAPS a power of two in 2..256");
    end

    logic [W-1:0]    hist_q [TAPS];
    logic [LG-1:0]   wp_q;
    logic [W+LG-1:0] acc_q, acc_d, rnd;
    logic [LG:0]     fill_q, fill_d;
    logic            out_valid_q, out_warm_q;
    logic [W+LG-1:0] out_sum_q;
    logic [W-1:0]    out_avg_q, avg_d;
    logic            accept;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // The evicted sample is already part of acc, so the subtraction cannot underflow.
    assign acc_d    = acc_q + (W+LG)'(in_data) - (W+LG)'(hist_q[wp_q]);
    assign fill_d   = (fill_q == (LG+1)'(TAPS)) ? fill_q : fill_q + 1'b1;
`ifdef FIR_AVG_ROUND_EN
    assign rnd      = acc_d + (W+LG)'(TAPS / 2);
`else
    assign rnd      = acc_d;
`endif
    assign avg_d    = W'(rnd >> LG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
            wp_q        <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            out_warm_q  <= 1'b0;
        end else if (accept) begin
            hist_q[wp_q] <= in_data;
            wp_q         <= wp_q + 1'b1;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            out_valid_q  <= 1'b1;
            out_sum_q    <= acc_d;
            out_avg_q    <= avg_d;
            out_warm_q   <= fill_q >= (LG+1)'(TAPS - 1);
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_avg   = out_avg_q;
    assign out_warm  = out_warm_q;
endmodule
